// File: rtl/t05_hist_engine.sv
// ---------------------------------------------------------------------------------------------
// t05_hist_engine
//
// Histogram engine. Accepts symbols from the SPI byte stream over a valid/ready handshake and
// performs a read-modify-write of one saturating count per symbol value in an external SRAM.
// Each pass starts by clearing the whole table. The pass ends on the EOF_SYM symbol, which
// is not counted, and the engine then reports the number of counted symbols.
//
// Parameters
//   SYM_W    symbol width; the table holds 2**SYM_W entries
//   CNT_W    per-symbol count width (saturating)
//   TOT_W    total-symbol counter width (saturating)
//   RD_LAT   SRAM read latency in cycles (>= 1)
//   EOF_SYM  end-of-file symbol
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   start        1-cycle pulse: clear the table and begin a pass (honoured in IDLE/HALT only)
//   in_valid     in_data is valid
//   in_data      symbol from the SPI front end
//   in_ready     engine accepts in_data this cycle (registered, ACCEPT only)
//   sram_addr    SRAM address
//   sram_re      SRAM read strobe
//   sram_we      SRAM write strobe
//   sram_wdata   SRAM write data
//   sram_rdata   SRAM read data, valid RD_LAT cycles after the sram_re cycle
//   busy         high in CLEAR/ACCEPT/RD/WAIT/WR
//   eof          sticky: EOF_SYM accepted; held until the next start
//   total        number of counted (non-EOF) symbols this pass
//   sat_flag     sticky: some count or the total saturated this pass
// ---------------------------------------------------------------------------------------------
module t05_hist_engine #(
    parameter int unsigned      SYM_W   = 8,
    parameter int unsigned      CNT_W   = 32,
    parameter int unsigned      TOT_W   = 32,
    parameter int unsigned      RD_LAT  = 2,
    parameter logic [SYM_W-1:0] EOF_SYM = SYM_W'('h1A)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_data,
    output logic             in_ready,
    output logic [SYM_W-1:0] sram_addr,
    output logic             sram_re,
    output logic             sram_we,
    output logic [CNT_W-1:0] sram_wdata,
    input  logic [CNT_W-1:0] sram_rdata,
    output logic             busy,
    output logic             eof,
    output logic [TOT_W-1:0] total,
    output logic             sat_flag
);

    // The WAIT counter only has to reach RD_LAT-2; keep it at least one bit wide.
    localparam int unsigned     WAIT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccept,
        StRd,
        StWait,
        StWr,
        StHalt
    } state_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              in_ready_q;
    logic [SYM_W-1:0]  sram_addr_q;
    logic              sram_re_q;
    logic              sram_we_q;
    logic              busy_q;
    logic              eof_q;
    logic [TOT_W-1:0]  total_q;
    logic              sat_q;

    logic              cnt_full;
    logic [CNT_W-1:0]  cnt_next;
    logic              total_full;

    // Read data only arrives in the WR cycle itself (RD_LAT cycles after RD), so the
    // incremented count has to be formed combinationally from sram_rdata.
    always_comb begin
        cnt_full   = (sram_rdata == {CNT_W{1'b1}});
        cnt_next   = cnt_full ? sram_rdata : sram_rdata + CNT_W'(1);
        total_full = (total_q == {TOT_W{1'b1}});
        sram_wdata = (state_q == StWr) ? cnt_next : '0;
    end

    // sram_addr_q doubles as the latched symbol: it is loaded on the accepting handshake and
    // held unchanged through RD, WAIT and WR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_re_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            eof_q       <= 1'b0;
            total_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            sram_re_q <= 1'b0;
            sram_we_q <= 1'b0;

            unique case (state_q)
                StIdle, StHalt: begin
                    if (start) begin
                        state_q     <= StClear;
                        busy_q      <= 1'b1;
                        eof_q       <= 1'b0;
                        sat_q       <= 1'b0;
                        total_q     <= '0;
                        sram_addr_q <= '0;
                        sram_we_q   <= 1'b1;
                    end
                end

                StClear: begin
                    if (sram_addr_q == {SYM_W{1'b1}}) begin
                        state_q    <= StAccept;
                        in_ready_q <= 1'b1;
                    end else begin
                        sram_addr_q <= sram_addr_q + SYM_W'(1);
                        sram_we_q   <= 1'b1;
                    end
                end

                StAccept: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (in_data == EOF_SYM) begin
                            state_q <= StHalt;
                            eof_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= StRd;
                            sram_addr_q <= in_data;
                            sram_re_q   <= 1'b1;
                        end
                    end
                end

                StRd: begin
                    if (total_full) begin
                        sat_q <= 1'b1;
                    end else begin
                        total_q <= total_q + TOT_W'(1);
                    end
                    if (RD_LAT == 1) begin
                        state_q   <= StWr;
                        sram_we_q <= 1'b1;
                    end else begin
                        state_q    <= StWait;
                        wait_cnt_q <= '0;
                    end
                end

                StWait: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q   <= StWr;
                        sram_we_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end

                StWr: begin
                    if (cnt_full) begin
                        sat_q <= 1'b1;
                    end
                    state_q    <= StAccept;
                    in_ready_q <= 1'b1;
                end

                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign sram_addr = sram_addr_q;
    assign sram_re   = sram_re_q;
    assign sram_we   = sram_we_q;
    assign busy      = busy_q;
    assign eof       = eof_q;
    assign total     = total_q;
    assign sat_flag  = sat_q;

    // A read and a write never share a cycle, and in_ready is only ever seen in ACCEPT.
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(sram_re_q && sram_we_q));
    a_ready_accept: assert property (@(posedge clk) disable iff (rst)
        in_ready_q |-> (state_q == StAccept));

endmodule

// File: tb/tb_t05_hist_engine.sv
// ---------------------------------------------------------------------------------------------
// tb_t05_hist_engine
//
// Four engine instances, each with its own SRAM model:
//   inst 0: CNT_W=32, RD_LAT=2   inst 1: CNT_W=4, RD_LAT=2
//   inst 2: CNT_W=32, RD_LAT=1   inst 3: CNT_W=32, RD_LAT=3
// Directed vectors with hand-computed expectations, plus hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------------------------
module tb_t05_hist_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       start_v, valid_v;
    logic [3:0][7:0]  data_v;
    logic [3:0]       ready_v, re_v, we_v, busy_v, eof_v, sat_v;
    logic [3:0][7:0]  addr_v;
    logic [3:0][31:0] wdata_v, total_v;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int unsigned CW = (g == 1) ? 4 : 32;
        localparam int unsigned RL = (g == 2) ? 1 : ((g == 3) ? 3 : 2);

        logic [CW-1:0] wdata, rdata;
        logic [7:0]    addr;
        logic [31:0]   total;
        logic          ready, re, we, busy, eof, sat;
        logic [CW-1:0] mem [256];
        logic [CW-1:0] pipe [RL];
        int re_cnt = 0;
        int we_cnt = 0;
        int both_cnt = 0;

        t05_hist_engine #(
            .SYM_W  (8),
            .CNT_W  (CW),
            .TOT_W  (32),
            .RD_LAT (RL),
            .EOF_SYM(8'h1A)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .in_valid  (valid_v[g]),
            .in_data   (data_v[g]),
            .in_ready  (ready),
            .sram_addr (addr),
            .sram_re   (re),
            .sram_we   (we),
            .sram_wdata(wdata),
            .sram_rdata(rdata),
            .busy      (busy),
            .eof       (eof),
            .total     (total),
            .sat_flag  (sat)
        );

        // SRAM model: data for a read in cycle t is presented during cycle t+RL; non-read
        // cycles return all-ones so a mistimed write-back is visible in the table.
        always @(posedge clk) begin
            if (rst) begin
                for (int a = 0; a < 256; a++) mem[a] <= CW'(32'hA5A5_A500 + a);
            end else if (we) begin
                mem[addr] <= wdata;
            end
            pipe[0] <= re ? mem[addr] : '1;
            for (int k = 1; k < int'(RL); k++) pipe[k] <= pipe[k-1];
            if (re) re_cnt <= re_cnt + 1;
            if (we) we_cnt <= we_cnt + 1;
            if (re && we) both_cnt <= both_cnt + 1;
        end
        assign rdata = pipe[RL-1];

        assign ready_v[g] = ready;
        assign re_v[g]    = re;
        assign we_v[g]    = we;
        assign busy_v[g]  = busy;
        assign eof_v[g]   = eof;
        assign sat_v[g]   = sat;
        assign addr_v[g]  = addr;
        assign wdata_v[g] = 32'(wdata);
        assign total_v[g] = total;
    end

    function automatic logic [31:0] mem_rd(input int i, input logic [7:0] a);
        case (i)
            0:       return 32'(g_inst[0].mem[a]);
            1:       return 32'(g_inst[1].mem[a]);
            2:       return 32'(g_inst[2].mem[a]);
            default: return 32'(g_inst[3].mem[a]);
        endcase
    endfunction

    function automatic int re_cnt_of(input int i);
        case (i)
            0:       return g_inst[0].re_cnt;
            1:       return g_inst[1].re_cnt;
            2:       return g_inst[2].re_cnt;
            default: return g_inst[3].re_cnt;
        endcase
    endfunction

    function automatic int strobe_sum();
        return g_inst[0].re_cnt + g_inst[0].we_cnt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one symbol; returns the cycle in which the handshake happened.
    task automatic send(input int i, input logic [7:0] s, input int gap, output int hs_cyc);
        int n;
        repeat (gap) @(negedge clk);
        valid_v[i] = 1'b1;
        data_v[i]  = s;
        n = 0;
        while (!ready_v[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check($sformatf("inst%0d handshake timeout", i), 32'(ready_v[i]), 1);
        hs_cyc = cyc;
        @(negedge clk);
        valid_v[i] = 1'b0;
    endtask

    task automatic wait_settle(input int i);
        int n;
        n = 0;
        while (!(ready_v[i] || eof_v[i]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check($sformatf("inst%0d settle timeout", i), 32'(ready_v[i] | eof_v[i]), 1);
    endtask

    task automatic start_pass(input int i);
        int n;
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        n = 0;
        while (!ready_v[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("inst%0d ready after clear", i), 32'(ready_v[i]), 1);
    endtask

    typedef struct {
        int         inst;
        bit         do_start;
        logic [7:0] sym;
        int         gap;
        int         exp_space;   // -1: spacing not checked
        int         exp_total;
        bit         exp_eof;
    } vec_t;

    typedef struct {
        int         inst;
        logic [7:0] addr;
        int         exp;
    } mem_chk_t;

    vec_t     vecs[$];
    mem_chk_t mchk[$];

    task automatic add_vec(input int i, input bit st, input logic [7:0] s, input int gap,
                           input int sp, input int tot, input bit e);
        vec_t v;
        v.inst = i; v.do_start = st; v.sym = s; v.gap = gap;
        v.exp_space = sp; v.exp_total = tot; v.exp_eof = e;
        vecs.push_back(v);
    endtask

    task automatic add_scen3(input int i, input bit st, input int rl);
        add_vec(i, st, 8'h41, 2, -1,     1, 1'b0);
        add_vec(i, 0,  8'h41, 0, rl + 2, 2, 1'b0);
        add_vec(i, 0,  8'h42, 3, -1,     3, 1'b0);
        add_vec(i, 0,  8'h1A, 1, -1,     3, 1'b1);
    endtask

    task automatic add_mchk(input int i, input logic [7:0] a, input int e);
        mem_chk_t m;
        m.inst = i; m.addr = a; m.exp = e;
        mchk.push_back(m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int bad;
        int hs;
        int last_hs;
        int re0;
        int snap;

        // Vector tables: scenario 3 on RD_LAT 2/1/3, saturation on the CNT_W=4 build.
        add_scen3(0, 1'b0, 2);
        add_scen3(2, 1'b1, 1);
        add_scen3(3, 1'b1, 3);
        for (int k = 0; k < 17; k++) add_vec(1, k == 0, 8'h05, k % 3, -1, k + 1, 1'b0);
        add_vec(1, 1'b0, 8'h1A, 0, -1, 17, 1'b1);

        add_mchk(0, 8'h41, 2);  add_mchk(0, 8'h42, 1);  add_mchk(0, 8'h1A, 0);
        add_mchk(0, 8'h00, 0);  add_mchk(0, 8'hFF, 0);
        add_mchk(2, 8'h41, 2);  add_mchk(2, 8'h42, 1);
        add_mchk(3, 8'h41, 2);  add_mchk(3, 8'h42, 1);
        add_mchk(1, 8'h05, 15); add_mchk(1, 8'h06, 0);

        rst = 1'b1;
        start_v = '0;
        valid_v = '0;
        data_v  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst in_ready", 32'(ready_v[0]), 0);
        check("rst sram_re",  32'(re_v[0]), 0);
        check("rst sram_we",  32'(we_v[0]), 0);
        check("rst busy",     32'(busy_v[0]), 0);
        check("rst eof",      32'(eof_v[0]), 0);
        check("rst sat_flag", 32'(sat_v[0]), 0);
        check("rst addr",     32'(addr_v[0]), 0);
        check("rst wdata",    wdata_v[0], 0);
        check("rst total",    total_v[0], 0);

        // Clear sweep: 256 write cycles of zero over addresses 0x00..0xFF
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (we_v[0] !== 1'b1 || addr_v[0] !== 8'(k) || wdata_v[0] !== 32'd0 ||
                ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || re_v[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        check("clear bad cycles", 32'(bad), 0);
        check("clear end we",     32'(we_v[0]), 0);
        check("clear end ready",  32'(ready_v[0]), 1);

        // Table-driven stream vectors
        last_hs = 0;
        foreach (vecs[v]) begin
            if (vecs[v].do_start) start_pass(vecs[v].inst);
            send(vecs[v].inst, vecs[v].sym, vecs[v].gap, hs);
            if (vecs[v].exp_space >= 0)
                check($sformatf("v%0d in_ready spacing", v), 32'(hs - last_hs),
                      32'(vecs[v].exp_space));
            last_hs = hs;
            wait_settle(vecs[v].inst);
            check($sformatf("v%0d total", v), total_v[vecs[v].inst], 32'(vecs[v].exp_total));
            check($sformatf("v%0d eof", v), 32'(eof_v[vecs[v].inst]), 32'(vecs[v].exp_eof));
        end

        foreach (mchk[m])
            check($sformatf("inst%0d mem[%0h]", mchk[m].inst, mchk[m].addr),
                  mem_rd(mchk[m].inst, mchk[m].addr), 32'(mchk[m].exp));

        check("inst0 busy after eof",   32'(busy_v[0]), 0);
        check("inst0 in_ready in halt", 32'(ready_v[0]), 0);
        check("inst0 sat_flag",         32'(sat_v[0]), 0);
        check("inst1 sat_flag",         32'(sat_v[1]), 1);
        check("inst3 sat_flag",         32'(sat_v[3]), 0);
        check("re/we overlap", 32'(g_inst[0].both_cnt + g_inst[1].both_cnt +
                                   g_inst[2].both_cnt + g_inst[3].both_cnt), 0);

        // Restart from HALT, then EOF as the very first symbol
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("halt start eof cleared", 32'(eof_v[0]), 0);
        check("halt start busy",        32'(busy_v[0]), 1);
        check("halt start total",       total_v[0], 0);
        bad = 0;
        while (!ready_v[0] && bad < 400) begin
            @(negedge clk);
            bad++;
        end
        check("re-clear ready", 32'(ready_v[0]), 1);
        check("re-clear mem[41]", mem_rd(0, 8'h41), 0);

        // start while in ACCEPT must be ignored
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("start ignored ready", 32'(ready_v[0]), 1);
        check("start ignored we",    32'(we_v[0]), 0);

        re0 = re_cnt_of(0);
        send(0, 8'h1A, 0, hs);
        wait_settle(0);
        check("eof-first total", total_v[0], 0);
        check("eof-first eof",   32'(eof_v[0]), 1);
        check("eof-first busy",  32'(busy_v[0]), 0);
        check("eof-first no re", 32'(re_cnt_of(0) - re0), 0);

        // Asynchronous reset in the middle of a write-back
        start_pass(0);
        send(0, 8'h33, 0, hs);
        bad = 0;
        while (!we_v[0] && bad < 10) begin
            @(negedge clk);
            bad++;
        end
        check("reached WR", 32'(we_v[0]), 1);
        rst = 1'b1;
        #1;
        check("async rst we",    32'(we_v[0]), 0);
        check("async rst re",    32'(re_v[0]), 0);
        check("async rst ready", 32'(ready_v[0]), 0);
        check("async rst busy",  32'(busy_v[0]), 0);
        check("async rst eof",   32'(eof_v[0]), 0);
        check("async rst sat",   32'(sat_v[0]), 0);
        check("async rst addr",  32'(addr_v[0]), 0);
        check("async rst wdata", wdata_v[0], 0);
        check("async rst total", total_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        snap = strobe_sum();
        repeat (5) @(negedge clk);
        check("post-rst no strobes", 32'(strobe_sum() - snap), 0);
        check("post-rst idle ready", 32'(ready_v[0]), 0);
        check("post-rst idle busy",  32'(busy_v[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
